// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller sitting on the consumer side of the ID/EX pipeline
// register. It looks at the ID/EX control fields and the IF/ID source
// registers and drives stall/flush/bubble controls back into PC, IF/ID and
// ID/EX. Load-use hazards stall the front end; EX-stage redirects (taken
// branch or jump) flush IF/ID and bubble ID/EX. A two-state FSM stretches
// load-use stalls to LOAD_STALL_CYCLES cycles for multi-cycle data memory.
//
// Control outputs are Mealy (state + current inputs) so a hazard is stalled
// in the same cycle it is seen.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall_count / flush_count performance counters. Without it both outputs
// are tied to zero and no counter flops exist.
//
// Parameters:
//   LOAD_STALL_CYCLES  stall cycles per load-use hazard (1..15)
//   CNT_W              performance counter width
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ifid_valid          IF/ID holds a real instruction
//   ifid_rs, ifid_rt    source registers of the instruction in ID
//   ifid_uses_rt        ID instruction reads rt
//   idex_memread        ID/EX instruction is a load
//   idex_regrt          load destination register in ID/EX
//   idex_branch         ID/EX instruction is a branch
//   idex_jump           ID/EX instruction is a jump
//   branch_taken        EX branch comparison result
//   pc_write            PC load enable
//   ifid_write          IF/ID load enable
//   ifid_flush          load a NOP into IF/ID
//   idex_bubble         zero ID/EX control bits on next load
//   stalling            FSM is in STALL
//   stall_count         hazard stall cycles since reset (saturating)
//   flush_count         redirect flushes since reset (saturating)
//
// State table:
//   state | meaning
//   RUN   | normal issue; single-cycle stalls and redirects handled here
//   STALL | extended load-use stall, scnt counts remaining cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifid_valid,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_regrt,
  input  logic             idex_branch,
  input  logic             idex_jump,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stalling,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // The first stall cycle is spent in RUN, so STALL covers the remainder.
  localparam logic [3:0] SCNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  logic [3:0] scnt;
  logic       load_use;
  logic       redirect;

  always_comb begin
    load_use = ifid_valid & idex_memread & (idex_regrt != 5'd0) &
               ((idex_regrt == ifid_rs) |
                (ifid_uses_rt & (idex_regrt == ifid_rt)));
    redirect = idex_jump | (idex_branch & branch_taken);
  end

  // Mealy control outputs. Reset forces a flushed, frozen front end.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (redirect) begin
      // Redirect wins over any stall, including an extended one in STALL.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state == STALL) || load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign stalling = (state == STALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      scnt  <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (!redirect && load_use && (LOAD_STALL_CYCLES > 1)) begin
            state <= STALL;
            scnt  <= SCNT_INIT;
          end
        end
        STALL: begin
          if (redirect) begin
            state <= RUN;
            scnt  <= 4'd0;
          end else begin
            if (scnt == 4'd1) begin
              state <= RUN;
            end
            scnt <= scnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
          scnt  <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (ifid_flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Four instances share one set of inputs:
//   d1  LOAD_STALL_CYCLES=1, CNT_W=16
//   d3  LOAD_STALL_CYCLES=3, CNT_W=16
//   d4  LOAD_STALL_CYCLES=4, CNT_W=16
//   ds  LOAD_STALL_CYCLES=1, CNT_W=4  (counter saturation)
// Each scenario starts from a reset so the instances not under test cannot
// disturb it. Counter expectations follow HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ifid_valid;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       idex_memread;
  logic [4:0] idex_regrt;
  logic       idex_branch;
  logic       idex_jump;
  logic       branch_taken;

  logic        pw1, iw1, fl1, bb1, st1;
  logic [15:0] sc1, fc1;
  logic        pw3, iw3, fl3, bb3, st3;
  logic [15:0] sc3, fc3;
  logic        pw4, iw4, fl4, bb4, st4;
  logic [15:0] sc4, fc4;
  logic        pws, iws, fls, bbs, sts;
  logic [3:0]  scs, fcs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread),
    .idex_regrt(idex_regrt), .idex_branch(idex_branch), .idex_jump(idex_jump),
    .branch_taken(branch_taken), .pc_write(pw1), .ifid_write(iw1),
    .ifid_flush(fl1), .idex_bubble(bb1), .stalling(st1),
    .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread),
    .idex_regrt(idex_regrt), .idex_branch(idex_branch), .idex_jump(idex_jump),
    .branch_taken(branch_taken), .pc_write(pw3), .ifid_write(iw3),
    .ifid_flush(fl3), .idex_bubble(bb3), .stalling(st3),
    .stall_count(sc3), .flush_count(fc3));

  hazard_ctrl #(.LOAD_STALL_CYCLES(4), .CNT_W(16)) d4 (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread),
    .idex_regrt(idex_regrt), .idex_branch(idex_branch), .idex_jump(idex_jump),
    .branch_taken(branch_taken), .pc_write(pw4), .ifid_write(iw4),
    .ifid_flush(fl4), .idex_bubble(bb4), .stalling(st4),
    .stall_count(sc4), .flush_count(fc4));

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) ds (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread),
    .idex_regrt(idex_regrt), .idex_branch(idex_branch), .idex_jump(idex_jump),
    .branch_taken(branch_taken), .pc_write(pws), .ifid_write(iws),
    .ifid_flush(fls), .idex_bubble(bbs), .stalling(sts),
    .stall_count(scs), .flush_count(fcs));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Benign inputs: valid instruction, no load, no redirect.
  task automatic idle();
    ifid_valid   = 1'b1;
    ifid_rs      = 5'd1;
    ifid_rt      = 5'd2;
    ifid_uses_rt = 1'b0;
    idex_memread = 1'b0;
    idex_regrt   = 5'd0;
    idex_branch  = 1'b0;
    idex_jump    = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic hazard_rs8();
    idle();
    idex_memread = 1'b1;
    idex_regrt   = 5'd8;
    ifid_rs      = 5'd8;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_pc_write",    pw1, 1'b0);
    chk("rst_ifid_write",  iw1, 1'b0);
    chk("rst_ifid_flush",  fl1, 1'b1);
    chk("rst_idex_bubble", bb1, 1'b1);
    chk("rst_stalling",    st1, 1'b0);
    chk("rst_stall_cnt",   sc1, 0);
    chk("rst_flush_cnt",   fc1, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("run_pc_write",    pw1, 1'b1);
    chk("run_ifid_flush",  fl1, 1'b0);
    chk("run_idex_bubble", bb1, 1'b0);

    // Load-use on rs, single-cycle stall
    do_reset();
    hazard_rs8();
    @(negedge clk);
    chk("lu_rs_pc_write",    pw1, 1'b0);
    chk("lu_rs_ifid_write",  iw1, 1'b0);
    chk("lu_rs_idex_bubble", bb1, 1'b1);
    chk("lu_rs_ifid_flush",  fl1, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("lu_rs_release_pw",  pw1, 1'b1);
    chk("lu_rs_release_bb",  bb1, 1'b0);
    chk("lu_rs_stall_cnt",   sc1, CNT_ON * 1);

    // rt only matters when the ID instruction reads it
    tick();
    idle();
    idex_memread = 1'b1;
    idex_regrt   = 5'd9;
    ifid_rt      = 5'd9;
    ifid_rs      = 5'd3;
    @(negedge clk);
    chk("rt_unused_pw", pw1, 1'b1);
    ifid_uses_rt = 1'b1;
    #1;
    chk("rt_used_pw", pw1, 1'b0);
    chk("rt_used_bb", bb1, 1'b1);

    // Invalid ID slot suppresses load-use
    ifid_valid = 1'b0;
    #1;
    chk("invalid_no_stall", pw1, 1'b1);

    // Register 0 is never a hazard
    tick();
    idle();
    idex_memread = 1'b1;
    idex_regrt   = 5'd0;
    ifid_rs      = 5'd0;
    @(negedge clk);
    chk("r0_no_stall", pw1, 1'b1);
    chk("r0_no_bubble", bb1, 1'b0);

    // LOAD_STALL_CYCLES=3: three stall cycles, stalling on cycles 2 and 3
    do_reset();
    hazard_rs8();
    @(negedge clk);
    chk("ls3_c1_pw", pw3, 1'b0);
    chk("ls3_c1_st", st3, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("ls3_c2_pw", pw3, 1'b0);
    chk("ls3_c2_st", st3, 1'b1);
    chk("ls3_c2_bb", bb3, 1'b1);
    tick();
    @(negedge clk);
    chk("ls3_c3_pw", pw3, 1'b0);
    chk("ls3_c3_st", st3, 1'b1);
    tick();
    @(negedge clk);
    chk("ls3_c4_pw", pw3, 1'b1);
    chk("ls3_c4_st", st3, 1'b0);
    chk("ls3_stall_cnt", sc3, CNT_ON * 3);

    // Redirect inside STALL aborts it
    do_reset();
    hazard_rs8();
    tick();
    idle();
    idex_jump = 1'b1;
    @(negedge clk);
    chk("abort_st_before", st3, 1'b1);
    chk("abort_flush", fl3, 1'b1);
    chk("abort_pw", pw3, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("abort_st_after", st3, 1'b0);
    chk("abort_pw_after", pw3, 1'b1);

    // Taken branch beats a simultaneous load-use
    do_reset();
    hazard_rs8();
    idex_branch  = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    chk("br_lu_flush", fl1, 1'b1);
    chk("br_lu_bubble", bb1, 1'b1);
    chk("br_lu_pw", pw1, 1'b1);
    chk("br_lu_iw", iw1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("br_lu_flush_cnt", fc1, CNT_ON * 1);
    chk("br_lu_stall_cnt", sc1, 0);
    // Branch not taken is not a redirect
    idex_branch = 1'b1;
    #1;
    chk("br_nt_flush", fl1, 1'b0);
    // Jump redirects even with an invalid ID slot
    idex_jump  = 1'b1;
    ifid_valid = 1'b0;
    #1;
    chk("jmp_invalid_flush", fl1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("jmp_flush_cnt", fc1, CNT_ON * 2);

    // LOAD_STALL_CYCLES=4, reset during the 2nd stall cycle
    do_reset();
    hazard_rs8();
    @(negedge clk);
    chk("ls4_c1_pw", pw4, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("ls4_rst_pw", pw4, 1'b0);
    chk("ls4_rst_flush", fl4, 1'b1);
    chk("ls4_rst_st", st4, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ls4_post_pw", pw4, 1'b1);
    chk("ls4_post_st", st4, 1'b0);
    chk("ls4_post_sc", sc4, 0);
    chk("ls4_post_fc", fc4, 0);

    // 2^4+2 separate hazards: 4-bit counter saturates, 16-bit one does not
    do_reset();
    for (int i = 0; i < 18; i++) begin
      hazard_rs8();
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    chk("sat_cnt4", scs, CNT_ON * 15);
    chk("sat_cnt16", sc1, CNT_ON * 18);
    chk("sat_pw", pws, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
